// File: rtl/out_port_fifo_if.sv
// ---------------------------------------------------------------------------
// out_port_fifo_if
// Bundle between the core OUT path, the output-port FIFO and its consumer.
//   i_out_write / i_out_data : core write strobe and value (one per OUT)
//   o_stall                  : hint to core hazard logic to hold OUT issue
//   o_port                   : legacy mirror of the last accepted value
//   o_valid / o_data / i_ready : FIFO head toward the consumer
//   o_count                  : occupancy 0..DEPTH
//   o_overflow / i_clr_ovf   : sticky dropped-write flag and its clear
// Modport master is the environment (core + consumer); slave is the FIFO.
// ---------------------------------------------------------------------------
interface out_port_fifo_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int AW = $clog2(DEPTH);

    logic              i_out_write;
    logic [DATA_W-1:0] i_out_data;
    logic              o_stall;
    logic [DATA_W-1:0] o_port;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              i_ready;
    logic [AW:0]       o_count;
    logic              o_overflow;
    logic              i_clr_ovf;

    modport master (
        output i_out_write, i_out_data, i_ready, i_clr_ovf,
        input  o_stall, o_port, o_valid, o_data, o_count, o_overflow
    );

    modport slave (
        input  i_out_write, i_out_data, i_ready, i_clr_ovf,
        output o_stall, o_port, o_valid, o_data, o_count, o_overflow
    );
endinterface

// File: rtl/out_port_fifo.sv
// ---------------------------------------------------------------------------
// out_port_fifo
// Output-port buffer behind the core OUT path. Each accepted OUT value is
// queued in a DEPTH-entry first-word-fall-through FIFO and mirrored on
// o_port. A consumer drains the head via valid/ready. o_stall warns the core
// one entry early so a write already in flight still fits.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (clears pointers, count, mirror, flag)
//   bus : out_port_fifo_if.slave (write path, consumer handshake, status)
// ---------------------------------------------------------------------------
module out_port_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input logic              clk,
    input logic              rst,
    out_port_fifo_if.slave   bus
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - 1);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wrPtr_r;
    logic [AW-1:0]     rdPtr_r;
    logic [AW:0]       count_r;
    logic [DATA_W-1:0] port_r;
    logic              overflow_r;

    logic              notEmpty_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;

    // Handshake decode: a full FIFO still accepts a write when the head leaves.
    always_comb begin
        notEmpty_s = (count_r != {(AW+1){1'b0}});
        pop_s      = notEmpty_s & bus.i_ready;
        push_s     = bus.i_out_write & ((count_r < DEPTH_CNT) | pop_s);
        drop_s     = bus.i_out_write & ~push_s;
    end

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[wrPtr_r] <= bus.i_out_data;
        end
    end

    // Pointers, occupancy, port mirror and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_r    <= {AW{1'b0}};
            rdPtr_r    <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            port_r     <= {DATA_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                // Natural AW-bit overflow provides the modulo-DEPTH wrap.
                wrPtr_r <= wrPtr_r + {{(AW-1){1'b0}}, 1'b1};
                port_r  <= bus.i_out_data;
            end else begin
                wrPtr_r <= wrPtr_r;
                port_r  <= port_r;
            end

            if (pop_s) begin
                rdPtr_r <= rdPtr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rdPtr_r <= rdPtr_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase

            // A drop in the same cycle as a clear must leave the flag set.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (bus.i_clr_ovf) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Status and head outputs are pure functions of registered state, so
    // o_stall has no path from i_out_write.
    always_comb begin
        bus.o_valid    = notEmpty_s;
        bus.o_data     = mem_r[rdPtr_r];
        bus.o_count    = count_r;
        bus.o_stall    = (count_r >= STALL_CNT);
        bus.o_port     = port_r;
        bus.o_overflow = overflow_r;
    end
endmodule

// File: tb/tb_out_port_fifo.sv
module tb_out_port_fifo;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] sb [$];
    logic [DATA_W-1:0] mPort;
    logic              mOvf;

    out_port_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    out_port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus, applied and sampled on the falling edge. The
    // scoreboard decides acceptance from its own occupancy; on a modelled pop
    // it hands back the expected head and the DUT head seen before the edge.
    task automatic step(input logic wr, input logic [15:0] d, input logic rdy,
                        input logic clr, output bit didPop,
                        output logic [15:0] expHead, output logic [15:0] obs);
        bit doPush;
        bus.i_out_write = wr;
        bus.i_out_data  = d;
        bus.i_ready     = rdy;
        bus.i_clr_ovf   = clr;
        obs     = bus.o_data;
        expHead = 16'h0000;
        didPop  = (sb.size() != 0) && rdy;
        doPush  = wr && ((sb.size() < DEPTH) || didPop);
        if (didPop) expHead = sb.pop_front();
        if (doPush) begin
            sb.push_back(d);
            mPort = d;
        end
        if (wr && !doPush) mOvf = 1'b1;
        else if (clr)      mOvf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.i_out_write = 1'b0;
        bus.i_out_data  = 16'h0000;
        bus.i_ready     = 1'b0;
        bus.i_clr_ovf   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        mPort = 16'h0000;
        mOvf  = 1'b0;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0 || bus.o_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: valid=%b count=%0d stall=%b, expected 0/0/0",
                     bus.o_valid, bus.o_count, bus.o_stall);
        end
        checks++;
        if (bus.o_port !== 16'h0000 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_port: port=%h ovf=%b, expected 0000/0", bus.o_port, bus.o_overflow);
        end
    endtask

    task automatic test_single();
        bit p;
        logic [15:0] e, o;
        step(1'b1, 16'h00A5, 1'b0, 1'b0, p, e, o);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h00A5 || bus.o_port !== 16'h00A5 || bus.o_count !== 4'd1) begin
            errors++;
            $display("FAIL single_write: valid=%b data=%h port=%h count=%0d, expected 1/00a5/00a5/1",
                     bus.o_valid, bus.o_data, bus.o_port, bus.o_count);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0, p, e, o);
        checks++;
        if (!p || o !== e || e !== 16'h00A5) begin
            errors++;
            $display("FAIL single_pop: popped=%b got=%h, expected 00a5", p, o);
        end
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            errors++;
            $display("FAIL single_empty: valid=%b count=%0d, expected 0/0", bus.o_valid, bus.o_count);
        end
    endtask

    task automatic fill(input int n, input logic [15:0] base);
        bit p;
        logic [15:0] e, o;
        for (int i = 1; i <= n; i++) begin
            step(1'b1, base + 16'(i), 1'b0, 1'b0, p, e, o);
            checks++;
            if (bus.o_count !== 4'(sb.size()) || bus.o_stall !== (sb.size() >= DEPTH - 1)) begin
                errors++;
                $display("FAIL fill_%0d: count=%0d stall=%b, expected %0d/%b", i, bus.o_count,
                         bus.o_stall, sb.size(), (sb.size() >= DEPTH - 1));
            end
        end
    endtask

    task automatic drain(input string tag);
        bit p;
        logic [15:0] e, o;
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            step(1'b0, 16'h0000, 1'b1, 1'b0, p, e, o);
            checks++;
            if (!p || o !== e) begin
                errors++;
                $display("FAIL %s_order: got=%h, expected %h", tag, o, e);
            end
        end
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_count !== 4'd0) begin
            errors++;
            $display("FAIL %s_empty: valid=%b count=%0d, expected 0/0", tag, bus.o_valid, bus.o_count);
        end
    endtask

    task automatic test_fill_drain();
        fill(8, 16'h0000);
        checks++;
        if (bus.o_count !== 4'd8 || bus.o_stall !== 1'b1) begin
            errors++;
            $display("FAIL full_status: count=%0d stall=%b, expected 8/1", bus.o_count, bus.o_stall);
        end
        drain("drain");
    endtask

    task automatic test_overflow_and_full_pushpop();
        bit p;
        logic [15:0] e, o;
        fill(8, 16'h0000);
        step(1'b1, 16'h1234, 1'b0, 1'b0, p, e, o);
        checks++;
        if (bus.o_overflow !== 1'b1 || bus.o_count !== 4'd8 || bus.o_port !== 16'h0008) begin
            errors++;
            $display("FAIL overflow_drop: ovf=%b count=%0d port=%h, expected 1/8/0008",
                     bus.o_overflow, bus.o_count, bus.o_port);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1, p, e, o);
        checks++;
        if (bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear: ovf=%b, expected 0", bus.o_overflow);
        end
        step(1'b1, 16'h5555, 1'b0, 1'b1, p, e, o);
        checks++;
        if (bus.o_overflow !== mOvf || mOvf !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set_wins: ovf=%b, expected 1", bus.o_overflow);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b1, p, e, o);
        step(1'b1, 16'h0009, 1'b1, 1'b0, p, e, o);
        checks++;
        if (!p || o !== e || e !== 16'h0001) begin
            errors++;
            $display("FAIL full_pushpop_head: got=%h, expected 0001", o);
        end
        checks++;
        if (bus.o_count !== 4'd8 || bus.o_port !== 16'h0009 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop_state: count=%0d port=%h ovf=%b, expected 8/0009/0",
                     bus.o_count, bus.o_port, bus.o_overflow);
        end
        drain("wrap");
    endtask

    task automatic test_stream();
        bit p;
        logic [15:0] e, o;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, p, e, o);
            checks++;
            if ((p && o !== e) || bus.o_count !== 4'(sb.size()) || bus.o_port !== mPort) begin
                errors++;
                $display("FAIL stream_%0d: got=%h exp=%h count=%0d port=%h, expected count %0d port %h",
                         i, o, e, bus.o_count, bus.o_port, sb.size(), mPort);
            end
        end
        drain("stream");
    endtask

    task automatic test_reset_midstream();
        bit p;
        logic [15:0] e, o;
        fill(3, 16'h0A00);
        bus.i_out_write = 1'b1;
        bus.i_out_data  = 16'hBEEF;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.i_out_write = 1'b0;
        sb.delete();
        mPort = 16'h0000;
        mOvf  = 1'b0;
        checks++;
        if (bus.o_count !== 4'd0 || bus.o_valid !== 1'b0 || bus.o_port !== 16'h0000 || bus.o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: count=%0d valid=%b port=%h ovf=%b, expected 0/0/0000/0",
                     bus.o_count, bus.o_valid, bus.o_port, bus.o_overflow);
        end
        step(1'b0, 16'h0000, 1'b0, 1'b0, p, e, o);
        checks++;
        if (bus.o_count !== 4'd0 || bus.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_write_ignored: count=%0d valid=%b, expected 0/0", bus.o_count, bus.o_valid);
        end
        step(1'b1, 16'h0077, 1'b0, 1'b0, p, e, o);
        drain("post_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.i_out_write = 1'b0;
        bus.i_out_data  = 16'h0000;
        bus.i_ready     = 1'b0;
        bus.i_clr_ovf   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow_and_full_pushpop();
        test_stream();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
